// File: rtl/ram_bist.sv
// March-style RAM self-test: two write/read rounds with a seeded address
// pattern, mismatch counting and first-failure capture.
module ram_bist #(
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter logic [15:0] END_ADDR     = 16'h00FF,
  parameter logic [7:0]  SEED         = 8'h5A,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  inout  wire  [7:0]  D,
  output logic [15:0] A,
  output logic        we,
  output logic        re,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_addr,
  output logic [7:0]  fail_exp,
  output logic [7:0]  fail_got
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] ERR_MAX = {AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_SAMPLE,
    S_DONE
  } state_e;

  state_e        state_q,     state_d;
  logic          round_q,     round_d;
  logic [AW-1:0] addr_q,      addr_d;
  logic          we_q,        we_d;
  logic          re_q,        re_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          pass_q,      pass_d;
  logic [AW-1:0] err_count_q, err_count_d;
  logic          fail_seen_q, fail_seen_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_exp_q,  fail_exp_d;
  logic [DW-1:0] fail_got_q,  fail_got_d;

  logic [DW-1:0] base_pat_c;
  logic [DW-1:0] pat_c;
  logic          last_c;
  logic          mismatch_c;
  logic [AW-1:0] err_inc_c;

  // Expected data for the current address and round.
  always_comb begin
    base_pat_c = addr_q[DW-1:0] ^ SEED;
    pat_c      = round_q ? ~base_pat_c : base_pat_c;
  end

  // The bus is driven only during write cycles; otherwise the RAM owns it.
  assign D = we_q ? pat_c : {DW{1'bz}};

  // End of pass is an explicit address compare so END_ADDR=FFFF cannot wrap.
  assign last_c     = (addr_q == END_ADDR);
  assign mismatch_c = (D != pat_c);
  assign err_inc_c  = (err_count_q == ERR_MAX) ? err_count_q
                                               : err_count_q + AW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          round_d     = 1'b0;
          addr_d      = START_ADDR;
          we_d        = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          fail_seen_d = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
        end
      end

      S_WRITE: begin
        if (last_c) begin
          state_d = S_RD_ADDR;
          addr_d  = START_ADDR;
          re_d    = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
          we_d   = 1'b1;
        end
      end

      S_RD_ADDR: begin
        state_d = S_RD_SAMPLE;
        re_d    = 1'b1;
      end

      S_RD_SAMPLE: begin
        if (mismatch_c) begin
          err_count_d = err_inc_c;
          if (!fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_addr_d = addr_q;
            fail_exp_d  = pat_c;
            fail_got_d  = D;
          end
        end
        if (mismatch_c && STOP_ON_FAIL) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (last_c) begin
          if (!round_q) begin
            state_d = S_WRITE;
            round_d = 1'b1;
            addr_d  = START_ADDR;
            we_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end
        end else begin
          state_d = S_RD_ADDR;
          addr_d  = addr_q + AW'(1);
          re_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      round_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  assign A         = addr_q;
  assign we        = we_q;
  assign re        = re_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule
